// File: rtl/rr_grant_arb.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Optional winner-hold input `lock` exists only when RR_ARB_LOCK_EN is defined.
module rr_grant_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant_oh
);

  localparam int unsigned W = NUM_REQ;
  localparam logic [W-1:0] LAST_RST = W'(1) << (W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [W-1:0] grant_n;
  logic [W-1:0] last_oh;
  logic [W-1:0] last_n;

  // First set bit of r strictly above the one-hot ptr, wrapping; ptr itself lowest priority.
  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] r, input logic [W-1:0] ptr);
    logic [W-1:0] above;
    logic [W-1:0] hi;
    above = ~((ptr << 1) - W'(1));
    hi    = r & above;
    if (hi != '0) begin
      return hi & (~hi + W'(1));
    end
    return r & (~r + W'(1));
  endfunction

`ifdef RR_ARB_LOCK_EN
  logic keep_c;
  assign keep_c = lock && ((req & grant_oh) != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      grant_oh  <= '0;
      last_oh   <= LAST_RST;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == HOLD);
      grant_oh  <= grant_n;
      last_oh   <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_oh;
    last_n  = last_oh;
    case (state)
      IDLE: begin
        if (req != '0) begin
          grant_n = rr_pick(req, last_oh);
          state_n = HOLD;
        end
      end
      HOLD: begin
        // out_valid is always high here, so out_ready alone marks a handshake.
        if (out_ready) begin
          last_n = grant_oh;
`ifdef RR_ARB_LOCK_EN
          if (keep_c) begin
            grant_n = grant_oh;
          end else
`endif
          if (req != '0) begin
            grant_n = rr_pick(req, grant_oh);
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
